// File: rtl/clkdiv_monitor.sv
// clkdiv_monitor
//   Receive-side checker for a divided/toggling signal. Measures the rise-to-rise
//   period and the high width of `din` in `clk` cycles, declares lock after
//   LOCK_CNT consecutive identical periods, and pulses `timeout` when no rising
//   edge arrives within MAX_PERIOD cycles.
//
//   Optional build macro: DIN_SYNC_EN -- passes `din` through a 2-flop
//   synchronizer (reset to 0) before edge detection, adding 2 cycles of latency.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   din        in   monitored divided-clock signal
//   period     out  [CW-1:0] last measured rise-to-rise period
//   high_time  out  [CW-1:0] last measured high width
//   meas_valid out  one-cycle pulse when period/high_time update
//   locked     out  level, LOCK_CNT consecutive identical periods seen
//   timeout    out  one-cycle pulse on loss of activity
module clkdiv_monitor #(
    parameter int unsigned CW         = 8,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned MAX_PERIOD = 200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          meas_valid,
    output logic          locked,
    output logic          timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [CW-1:0] CNT_SAT = '1;
    localparam logic [CW-1:0] MAX_P   = CW'(MAX_PERIOD);
    localparam logic [3:0]    LOCK_V  = 4'(LOCK_CNT);

    state_t        state;
    logic          din_e;
    logic          din_q;
    logic          rise;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] hi_cnt;
    logic [CW-1:0] last_per;
    logic [3:0]    match_cnt;
    logic [3:0]    match_nxt;

`ifdef DIN_SYNC_EN
    logic din_s1;
    logic din_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
        end
    end

    always_comb din_e = din_s2;
`else
    always_comb din_e = din;
`endif

    always_comb rise = din_e & ~din_q;

    // Match count after the current measurement. The first period measured out
    // of ARM has nothing to compare against, so it only seeds the run.
    always_comb begin
        match_nxt = 4'd1;
        if (state == MEAS && per_cnt == last_per)
            match_nxt = (match_cnt >= LOCK_V) ? LOCK_V : match_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            din_q      <= 1'b0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            last_per   <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            din_q      <= din_e;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt <= CW'(1);
                        hi_cnt  <= CW'(1);
                        state   <= ARM;
                    end
                end
                ARM, MEAS: begin
                    // A rise on the same cycle per_cnt reaches MAX_PERIOD is a
                    // valid measurement, so the rise branch is checked first.
                    if (rise) begin
                        period     <= per_cnt;
                        high_time  <= hi_cnt;
                        meas_valid <= 1'b1;
                        last_per   <= per_cnt;
                        match_cnt  <= match_nxt;
                        locked     <= (match_nxt == LOCK_V);
                        per_cnt    <= CW'(1);
                        hi_cnt     <= CW'(1);
                        state      <= MEAS;
                    end else if (per_cnt == MAX_P) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        if (per_cnt != CNT_SAT)
                            per_cnt <= per_cnt + CW'(1);
                        if (din_e && hi_cnt != CNT_SAT)
                            hi_cnt <= hi_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
module tb_clkdiv_monitor;

    localparam int unsigned CW   = 8;
    localparam int unsigned LOCK = 4;
    localparam int unsigned MAXP = 200;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          din = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    int tests  = 0;
    int failed = 0;

    clkdiv_monitor #(.CW(CW), .LOCK_CNT(LOCK), .MAX_PERIOD(MAXP)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: timestamps of rising edges and the list of measured periods
    int            cyc = 0;
    int            last_rise = 0;
    int            ones = 0;
    bit            m_armed = 0;
    logic          m_prev = 0;
    logic [1:0]    m_sync = '0;
    logic [CW-1:0] m_period = '0;
    logic [CW-1:0] m_high = '0;
    logic          m_mv = 0;
    logic          m_locked = 0;
    logic          m_to = 0;
    int            pers[$];
    logic          wq[$];

    task automatic tick(input logic d, input logic r);
        logic e;
        logic rise;
        int   run;
        din   = d;
        reset = r;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            m_armed = 0; m_prev = 0; m_sync = '0;
            m_period = '0; m_high = '0; m_mv = 0; m_locked = 0; m_to = 0;
            pers.delete();
        end else begin
`ifdef DIN_SYNC_EN
            e = m_sync[1];
            m_sync = {m_sync[0], d};
`else
            e = d;
`endif
            rise   = e & ~m_prev;
            m_prev = e;
            m_mv   = 0;
            m_to   = 0;
            if (!m_armed) begin
                if (rise) begin
                    m_armed = 1; last_rise = cyc; ones = 1;
                end
            end else if (rise) begin
                m_period = CW'(cyc - last_rise);
                m_high   = CW'(ones);
                m_mv     = 1;
                pers.push_back(cyc - last_rise);
                run = 0;
                for (int i = pers.size() - 1; i >= 0; i--) begin
                    if (pers[i] != pers[pers.size() - 1]) break;
                    run++;
                end
                m_locked  = (run >= LOCK);
                last_rise = cyc;
                ones      = 1;
            end else if (cyc - last_rise == MAXP) begin
                m_to = 1; m_locked = 0; m_armed = 0;
                pers.delete();
            end else if (e) begin
                ones++;
            end
        end
    endtask

    task automatic add_wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < hi; k++) wq.push_back(1'b1);
            for (int k = 0; k < lo; k++) wq.push_back(1'b0);
        end
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (period !== '0)     begin failed++; $display("FAIL reset_period got %0d exp 0", period); end
        tests++; if (high_time !== '0)  begin failed++; $display("FAIL reset_high got %0d exp 0", high_time); end
        tests++; if (meas_valid !== 0)  begin failed++; $display("FAIL reset_mv got %b exp 0", meas_valid); end
        tests++; if (locked !== 0)      begin failed++; $display("FAIL reset_locked got %b exp 0", locked); end
        tests++; if (timeout !== 0)     begin failed++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    endtask

    task automatic test_div3();
        int mvs = 0, first_mv_at = -1, lock_at = -1, i = 0;
        int exp_first;
        do_reset();
        wq.delete();
        add_wave(2, 1, 12);
        foreach (wq[j]) begin
            tick(wq[j], 1'b0);
            tests++;
            if ({period, high_time, meas_valid, locked, timeout} !== {m_period, m_high, m_mv, m_locked, m_to}) begin
                failed++;
                $display("FAIL div3 cyc %0d got p=%0d h=%0d mv=%b lk=%b to=%b exp p=%0d h=%0d mv=%b lk=%b to=%b",
                         i, period, high_time, meas_valid, locked, timeout, m_period, m_high, m_mv, m_locked, m_to);
            end
            if (meas_valid === 1'b1) begin
                mvs++;
                if (mvs == 1) begin
                    first_mv_at = i;
                    tests++;
                    if (period !== 8'd3 || high_time !== 8'd2) begin
                        failed++;
                        $display("FAIL div3_first got %0d/%0d exp 3/2", period, high_time);
                    end
                end
                if (locked === 1'b1 && lock_at < 0) lock_at = mvs;
            end
            i++;
        end
`ifdef DIN_SYNC_EN
        exp_first = 5;
`else
        exp_first = 3;
`endif
        tests++; if (first_mv_at != exp_first) begin failed++; $display("FAIL div3_latency got %0d exp %0d", first_mv_at, exp_first); end
        tests++; if (lock_at != int'(LOCK)) begin failed++; $display("FAIL div3_lock_at got %0d exp %0d", lock_at, LOCK); end
    endtask

    task automatic test_switch();
        int n4 = 0, relock = -1, drop_ok = -1, i = 0;
        do_reset();
        wq.delete();
        add_wave(1, 1, 8);
        add_wave(2, 2, 8);
        foreach (wq[j]) begin
            tick(wq[j], 1'b0);
            tests++;
            if ({period, high_time, meas_valid, locked, timeout} !== {m_period, m_high, m_mv, m_locked, m_to}) begin
                failed++;
                $display("FAIL switch cyc %0d got p=%0d h=%0d mv=%b lk=%b to=%b exp p=%0d h=%0d mv=%b lk=%b to=%b",
                         i, period, high_time, meas_valid, locked, timeout, m_period, m_high, m_mv, m_locked, m_to);
            end
            if (meas_valid === 1'b1 && period === 8'd4) begin
                n4++;
                if (n4 == 1) drop_ok = (locked === 1'b0 && high_time === 8'd2);
                if (locked === 1'b1 && relock < 0) relock = n4;
            end
            i++;
        end
        tests++; if (drop_ok != 1) begin failed++; $display("FAIL switch_drop got %0d exp 1", drop_ok); end
        tests++; if (relock != int'(LOCK)) begin failed++; $display("FAIL switch_relock got %0d exp %0d", relock, LOCK); end
    endtask

    task automatic test_timeout();
        int tos = 0, mv_after = 0, i = 0;
        do_reset();
        wq.delete();
        add_wave(2, 1, 8);
        for (int k = 0; k < 205; k++) wq.push_back(1'b0);
        add_wave(2, 1, 1);
        foreach (wq[j]) begin
            tick(wq[j], 1'b0);
            tests++;
            if ({period, high_time, meas_valid, locked, timeout} !== {m_period, m_high, m_mv, m_locked, m_to}) begin
                failed++;
                $display("FAIL timeout cyc %0d got p=%0d h=%0d mv=%b lk=%b to=%b exp p=%0d h=%0d mv=%b lk=%b to=%b",
                         i, period, high_time, meas_valid, locked, timeout, m_period, m_high, m_mv, m_locked, m_to);
            end
            if (timeout === 1'b1) begin
                tos++;
                tests++;
                if (period !== 8'd3 || locked !== 1'b0) begin
                    failed++;
                    $display("FAIL timeout_state got p=%0d lk=%b exp p=3 lk=0", period, locked);
                end
            end
            if (tos > 0 && meas_valid === 1'b1) mv_after++;
            i++;
        end
        tests++; if (tos != 1) begin failed++; $display("FAIL timeout_count got %0d exp 1", tos); end
        tests++; if (mv_after != 0) begin failed++; $display("FAIL timeout_rearm got %0d mv exp 0", mv_after); end
    endtask

    task automatic test_boundary();
        int tos = 0, got200 = 0, i = 0;
        do_reset();
        wq.delete();
        wq.push_back(1'b1);
        for (int k = 0; k < 199; k++) wq.push_back(1'b0);
        wq.push_back(1'b1);
        for (int k = 0; k < 3; k++) wq.push_back(1'b0);
        foreach (wq[j]) begin
            tick(wq[j], 1'b0);
            tests++;
            if ({period, high_time, meas_valid, locked, timeout} !== {m_period, m_high, m_mv, m_locked, m_to}) begin
                failed++;
                $display("FAIL boundary cyc %0d got p=%0d h=%0d mv=%b lk=%b to=%b exp p=%0d h=%0d mv=%b lk=%b to=%b",
                         i, period, high_time, meas_valid, locked, timeout, m_period, m_high, m_mv, m_locked, m_to);
            end
            if (timeout === 1'b1) tos++;
            if (meas_valid === 1'b1 && period === 8'd200 && high_time === 8'd1) got200++;
            i++;
        end
        tests++; if (got200 != 1) begin failed++; $display("FAIL boundary_200 got %0d exp 1", got200); end
        tests++; if (tos != 0) begin failed++; $display("FAIL boundary_no_timeout got %0d exp 0", tos); end
    endtask

    task automatic test_reset_mid();
        int mvs = 0, i = 0;
        logic [CW-1:0] first_p = '0;
        do_reset();
        wq.delete();
        add_wave(2, 1, 7);
        wq.push_back(1'b1);
        foreach (wq[j]) tick(wq[j], 1'b0);
        tests++; if (locked !== 1'b1) begin failed++; $display("FAIL resetmid_prelock got %b exp 1", locked); end
        tick(1'b1, 1'b1);
        tests++;
        if ({period, high_time, meas_valid, locked, timeout} !== '0) begin
            failed++;
            $display("FAIL resetmid_clear got p=%0d h=%0d mv=%b lk=%b to=%b exp all 0", period, high_time, meas_valid, locked, timeout);
        end
        wq.delete();
        wq.push_back(1'b0);
        add_wave(2, 1, 4);
        foreach (wq[j]) begin
            tick(wq[j], 1'b0);
            tests++;
            if ({period, high_time, meas_valid, locked, timeout} !== {m_period, m_high, m_mv, m_locked, m_to}) begin
                failed++;
                $display("FAIL resetmid cyc %0d got p=%0d h=%0d mv=%b lk=%b to=%b exp p=%0d h=%0d mv=%b lk=%b to=%b",
                         i, period, high_time, meas_valid, locked, timeout, m_period, m_high, m_mv, m_locked, m_to);
            end
            if (meas_valid === 1'b1) begin
                mvs++;
                if (mvs == 1) first_p = period;
            end
            i++;
        end
        tests++; if (first_p !== 8'd3) begin failed++; $display("FAIL resetmid_first got %0d exp 3", first_p); end
    endtask

    task automatic test_random();
        int i = 0;
        do_reset();
        wq.delete();
        for (int b = 0; b < 10; b++) begin
            add_wave(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), int'($urandom_range(3, 7)));
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < 210; k++) wq.push_back(1'($urandom_range(0, 1) == 0 ? 0 : (b % 2)));
        end
        foreach (wq[j]) begin
            tick(wq[j], 1'b0);
            tests++;
            if ({period, high_time, meas_valid, locked, timeout} !== {m_period, m_high, m_mv, m_locked, m_to}) begin
                failed++;
                $display("FAIL random cyc %0d got p=%0d h=%0d mv=%b lk=%b to=%b exp p=%0d h=%0d mv=%b lk=%b to=%b",
                         i, period, high_time, meas_valid, locked, timeout, m_period, m_high, m_mv, m_locked, m_to);
            end
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_div3();
        test_switch();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
